// File: rtl/i_deser_align.sv
// Serial-to-parallel deserialiser with word alignment by manual bitslip ("NONE")
// or by hunting for a training pattern ("AUTO").
module i_deser_align #(
    parameter int unsigned WIDTH         = 4,
    parameter string       ALIGN_MODE    = "NONE",
    parameter logic [9:0]  TRAIN_PATTERN = 10'h1A6,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             D,
    input  logic             EN,
    input  logic             BITSLIP_ADJ,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID,
    output logic             DPA_LOCK,
    output logic             DPA_ERROR
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam bit               AUTO    = (ALIGN_MODE == "AUTO");
    localparam logic [WIDTH-1:0] PATTERN = TRAIN_PATTERN[WIDTH-1:0];

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $error("i_deser_align: WIDTH must be in 3..10");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
        $error("i_deser_align: LOCK_COUNT must be in 1..15");
    end
    if (ALIGN_MODE != "NONE" && ALIGN_MODE != "AUTO") begin : g_bad_mode
        $error("i_deser_align: ALIGN_MODE must be \"NONE\" or \"AUTO\"");
    end

    typedef enum logic [1:0] {HUNT, SETTLE, LOCKED, ERROR} state_t;

    // The newest bit of a word is taken straight from D, so only WIDTH-1 older bits are stored.
    logic [WIDTH-2:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             slip_pend;
    logic             adj_q;
    logic [3:0]       match_cnt;
    logic [3:0]       slip_cnt;
    state_t           state;

    logic             adj_rise_c;
    logic [WIDTH-1:0] word_c;
    logic             word_done_c;
    logic             hunt_slip_c;
    logic             slip_req_c;

    assign adj_rise_c  = BITSLIP_ADJ & ~adj_q;
    assign word_c      = {shreg, D};
    assign word_done_c = EN && !slip_pend && (bit_cnt == CNT_W'(WIDTH - 1));
    assign hunt_slip_c = AUTO && !adj_rise_c && (state == HUNT) && DATA_VALID
                         && (Q != PATTERN) && (slip_cnt < 4'(WIDTH));
    assign slip_req_c  = AUTO ? hunt_slip_c : adj_rise_c;

    // Bit capture, word framing and slip handling
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            slip_pend  <= 1'b0;
            adj_q      <= 1'b0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            adj_q      <= BITSLIP_ADJ;
            DATA_VALID <= word_done_c;
            if (EN) begin
                shreg <= word_c[WIDTH-2:0];
                if (slip_pend) begin
                    slip_pend <= 1'b0;
                end else if (word_done_c) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (word_done_c) begin
                Q <= word_c;
            end
            // A request arriving while one is still outstanding is dropped.
            if (slip_req_c && !slip_pend) begin
                slip_pend <= 1'b1;
            end
        end
    end

    // Training-pattern alignment FSM; judges each word while it is presented on Q
    always_ff @(posedge CLK_IN) begin
        if (RST || !AUTO || adj_rise_c) begin
            state     <= HUNT;
            match_cnt <= '0;
            slip_cnt  <= '0;
            DPA_LOCK  <= 1'b0;
            DPA_ERROR <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (DATA_VALID) begin
                        if (Q == PATTERN) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
                                state    <= LOCKED;
                                DPA_LOCK <= 1'b1;
                            end
                        end else if (slip_cnt < 4'(WIDTH)) begin
                            match_cnt <= '0;
                            slip_cnt  <= slip_cnt + 4'd1;
                            state     <= SETTLE;
                        end else begin
                            state     <= ERROR;
                            DPA_ERROR <= 1'b1;
                        end
                    end
                end
                // The first word after a slip is passed through but not judged.
                SETTLE: begin
                    if (DATA_VALID) begin
                        state <= HUNT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
